ysyx_24100005_ifu: RTL and testbench
====================================

YSYX_24100005_IFU -- requirements
Module: ysyx_24100005_ifu

Interface
REQ-001 Parameter XLEN, default 32, SHALL set the width of the PC, address and counter.
REQ-002 Parameter RESET_PC, default 32'h8000_0000, SHALL set the PC value loaded on reset.
REQ-003 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 rst  input  1  SHALL be the reset: asynchronous, active-low.
REQ-005 imem_req_valid  output  1  SHALL indicate a fetch request.
REQ-006 imem_req_ready  input  1  SHALL indicate that memory accepts the request.
REQ-007 imem_req_addr  output  XLEN  SHALL carry the fetch address.
REQ-008 imem_resp_valid  input  1  SHALL indicate that the response data is valid.
REQ-009 imem_resp_data  input  32  SHALL carry the fetched instruction.
REQ-010 out_valid  output  1  SHALL indicate that an instruction is offered to decode.
REQ-011 out_ready  input  1  SHALL indicate that decode accepts the instruction.
REQ-012 out_inst  output  32  SHALL carry the offered instruction.
REQ-013 out_pc  output  XLEN  SHALL carry the PC of out_inst.
REQ-014 redirect_valid  input  1  SHALL request a PC redirect (branch/jump).
REQ-015 redirect_pc  input  XLEN  SHALL carry the redirect target.
REQ-016 halted  output  1  SHALL indicate that ebreak was consumed and fetch has stopped.
REQ-017 fetch_count  output  XLEN  SHALL count instructions handed to decode.

Function
REQ-018 The block SHALL implement a 4-state FSM: REQ, WAIT, OUT, HALT.
REQ-019 REQ SHALL be as follows: imem_req_valid = !redirect_valid; imem_req_addr = pc; on a valid&&ready handshake the FSM SHALL go to WAIT.
REQ-020 WAIT SHALL be as follows: on imem_resp_valid the block SHALL capture imem_resp_data and pc into the output buffer and go to OUT; no new request is issued in WAIT.
REQ-021 OUT SHALL be as follows: out_valid = !redirect_valid; on an out_valid&&out_ready handshake, fetch_count += 1 (wrap mod 2^XLEN).
REQ-022 On that handshake in OUT, if out_inst == 32'h0010_0073 (ebreak) the FSM SHALL go to HALT with pc unchanged; otherwise pc <= pc + 4 (wrap mod 2^XLEN) and the FSM SHALL go to REQ.
REQ-023 HALT SHALL be as follows: halted = 1; no requests, no out_valid; redirect is ignored; the state is sticky until reset.
REQ-024 A redirect in REQ or OUT SHALL have priority over the handshake: pc <= {redirect_pc[XLEN-1:2], 2'b00}, next state REQ, no handshake counted that cycle.
REQ-025 A redirect in WAIT SHALL load pc as in REQ-024 and set a kill flag; the FSM stays in WAIT.
REQ-026 A response arriving with kill set (or in the same cycle as the redirect) SHALL be dropped; kill SHALL be cleared and the FSM SHALL go to REQ with the new pc.
REQ-027 At most one request SHALL be outstanding; a response in any state other than WAIT SHALL be ignored.
REQ-028 The output buffer SHALL hold out_inst/out_pc stable while out_valid && !out_ready.
REQ-029 imem_req_addr SHALL always have bits [1:0] = 0.

Reset
REQ-030 While rst = 0, the block SHALL immediately force: state REQ, pc = RESET_PC, kill = 0, out_inst = 0, out_pc = 0, fetch_count = 0, halted = 0, imem_req_valid = 0, out_valid = 0.
REQ-031 Reset asserted mid-transaction (in WAIT or OUT) SHALL abandon the transaction; a late response after reset release SHALL be ignored per REQ-027.
REQ-032 The first request SHALL be issued in the first cycle after rst rises, with addr RESET_PC.

Verification
REQ-033 Basic fetch: release reset, memory ready at once, 1-cycle response 32'h0000_0013, out_ready = 1 -> out_pc 8000_0000, then 8000_0004, 8000_0008; fetch_count = 3 after three instructions.
REQ-034 Backpressure: out_ready = 0 for 5 cycles -> out_valid held, out_inst/out_pc stable, no new imem_req_valid; out_ready = 1 -> one count increment.
REQ-035 Redirect in WAIT: redirect_pc = 8000_0103 while waiting -> the pending response is dropped, the next imem_req_addr = 8000_0100, and no out_valid for the stale instruction.
REQ-036 Ebreak: the response 32'h0010_0073 is consumed -> halted = 1 next cycle, no further requests; a redirect afterwards has no effect; rst pulse -> halted = 0, request at 8000_0000.
REQ-037 Wrap: XLEN = 32, RESET_PC = 32'hFFFF_FFFC -> after one consumed instruction, the next request addr = 0000_0000.
REQ-038 Async reset: rst low mid-cycle in OUT -> out_valid = 0 before the next clock edge; all outputs at their REQ-030 values.

Source files
------------

// File: rtl/ysyx_24100005_ifu.sv
// Instruction fetch unit: one outstanding imem request, a one-entry
// output buffer to decode, redirect/kill handling and ebreak halt.
module ysyx_24100005_ifu #(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = 32'h8000_0000
) (
  input  logic            clk,
  input  logic            rst,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_resp_valid,
  input  logic [31:0]     imem_resp_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [31:0]     out_inst,
  output logic [XLEN-1:0] out_pc,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            halted,
  output logic [XLEN-1:0] fetch_count
);

  localparam logic [31:0] EBREAK = 32'h0010_0073;

  typedef enum logic [1:0] {
    S_REQ,
    S_WAIT,
    S_OUT,
    S_HALT
  } state_e;

  state_e          state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic            kill_q, kill_d;
  logic [31:0]     inst_q, inst_d;
  logic [XLEN-1:0] opc_q, opc_d;
  logic [XLEN-1:0] cnt_q, cnt_d;

  logic [XLEN-1:0] redir_pc;
  logic            req_fire;
  logic            out_fire;
  logic            is_ebreak;

  assign redir_pc  = {redirect_pc[XLEN-1:2], 2'b00};
  assign req_fire  = imem_req_valid && imem_req_ready;
  assign out_fire  = out_valid && out_ready;
  assign is_ebreak = (inst_q == EBREAK);

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_REQ;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; redirect outranks any handshake
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_REQ: begin
        if (!redirect_valid && req_fire) begin
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (imem_resp_valid) begin
          if (kill_q || redirect_valid) begin
            state_d = S_REQ;
          end else begin
            state_d = S_OUT;
          end
        end
      end
      S_OUT: begin
        if (redirect_valid) begin
          state_d = S_REQ;
        end else if (out_fire) begin
          state_d = is_ebreak ? S_HALT : S_REQ;
        end
      end
      S_HALT: begin
        state_d = S_HALT;
      end
      default: begin
        state_d = S_REQ;
      end
    endcase
  end

  // Outputs; gated by rst so they drop the instant reset asserts
  always_comb begin
    imem_req_valid = rst && (state_q == S_REQ) && !redirect_valid;
    imem_req_addr  = {pc_q[XLEN-1:2], 2'b00};
    out_valid      = rst && (state_q == S_OUT) && !redirect_valid;
    out_inst       = inst_q;
    out_pc         = opc_q;
    halted         = (state_q == S_HALT);
    fetch_count    = cnt_q;
  end

  // Datapath next values: pc, kill flag, output buffer, counter
  always_comb begin
    pc_d   = pc_q;
    kill_d = kill_q;
    inst_d = inst_q;
    opc_d  = opc_q;
    cnt_d  = cnt_q;
    unique case (state_q)
      S_REQ: begin
        if (redirect_valid) begin
          pc_d = redir_pc;
        end
      end
      S_WAIT: begin
        if (imem_resp_valid) begin
          if (kill_q || redirect_valid) begin
            kill_d = 1'b0;
            if (redirect_valid) begin
              pc_d = redir_pc;
            end
          end else begin
            inst_d = imem_resp_data;
            opc_d  = pc_q;
          end
        end else if (redirect_valid) begin
          pc_d   = redir_pc;
          kill_d = 1'b1;
        end
      end
      S_OUT: begin
        if (redirect_valid) begin
          pc_d = redir_pc;
        end else if (out_fire) begin
          cnt_d = cnt_q + XLEN'(1);
          if (!is_ebreak) begin
            pc_d = pc_q + XLEN'(4);
          end
        end
      end
      default: begin
        pc_d = pc_q;
      end
    endcase
  end

  // Datapath registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc_q   <= RESET_PC;
      kill_q <= 1'b0;
      inst_q <= 32'h0;
      opc_q  <= '0;
      cnt_q  <= '0;
    end else begin
      pc_q   <= pc_d;
      kill_q <= kill_d;
      inst_q <= inst_d;
      opc_q  <= opc_d;
      cnt_q  <= cnt_d;
    end
  end

endmodule

// File: tb/tb_ysyx_24100005_ifu.sv
// Bench for ysyx_24100005_ifu: vector table of fetches plus
// hand sequences for redirect, ebreak, async reset and pc wrap.
module tb_ysyx_24100005_ifu;

  localparam logic [31:0] EBREAK = 32'h0010_0073;

  typedef struct {
    logic [31:0] inst;
    int          lat;
    int          stall;
    logic [31:0] exp_pc;
    logic [31:0] exp_cnt;
  } vec_t;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
  } sb_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        rst2;
  logic        imem_req_ready;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;
  logic        out_ready;
  logic        redirect_valid;
  logic [31:0] redirect_pc;

  logic        imem_req_valid;
  logic [31:0] imem_req_addr;
  logic        out_valid;
  logic [31:0] out_inst;
  logic [31:0] out_pc;
  logic        halted;
  logic [31:0] fetch_count;

  logic        w_req_valid;
  logic [31:0] w_req_addr;
  logic        w_out_valid;
  logic [31:0] w_out_inst;
  logic [31:0] w_out_pc;
  logic        w_halted;
  logic [31:0] w_count;

  int n_chk = 0;
  int n_fail = 0;
  sb_t sb[$];
  vec_t vecs[5];

  always #5 clk = ~clk;

  ysyx_24100005_ifu u_dut (
    .clk             (clk),
    .rst             (rst),
    .imem_req_valid  (imem_req_valid),
    .imem_req_ready  (imem_req_ready),
    .imem_req_addr   (imem_req_addr),
    .imem_resp_valid (imem_resp_valid),
    .imem_resp_data  (imem_resp_data),
    .out_valid       (out_valid),
    .out_ready       (out_ready),
    .out_inst        (out_inst),
    .out_pc          (out_pc),
    .redirect_valid  (redirect_valid),
    .redirect_pc     (redirect_pc),
    .halted          (halted),
    .fetch_count     (fetch_count)
  );

  ysyx_24100005_ifu #(
    .XLEN     (32),
    .RESET_PC (32'hFFFF_FFFC)
  ) u_wrap (
    .clk             (clk),
    .rst             (rst2),
    .imem_req_valid  (w_req_valid),
    .imem_req_ready  (imem_req_ready),
    .imem_req_addr   (w_req_addr),
    .imem_resp_valid (imem_resp_valid),
    .imem_resp_data  (imem_resp_data),
    .out_valid       (w_out_valid),
    .out_ready       (out_ready),
    .out_inst        (w_out_inst),
    .out_pc          (w_out_pc),
    .redirect_valid  (redirect_valid),
    .redirect_pc     (redirect_pc),
    .halted          (w_halted),
    .fetch_count     (w_count)
  );

  task automatic check(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic fetch_one(input vec_t v);
    int  n;
    sb_t e;
    imem_req_ready = 1'b1;
    out_ready      = 1'b0;
    #1;
    n = 0;
    while (!imem_req_valid && n < 20) begin
      tick();
      #1;
      n++;
    end
    check("req_valid", {31'b0, imem_req_valid}, 32'd1);
    check("req_addr", imem_req_addr, v.exp_pc);
    sb.push_back('{v.exp_pc, v.inst});
    tick();
    imem_req_ready = 1'b0;
    repeat (v.lat) begin
      #1;
      check("no_req_in_wait", {31'b0, imem_req_valid}, 32'd0);
      tick();
    end
    imem_resp_valid = 1'b1;
    imem_resp_data  = v.inst;
    tick();
    imem_resp_valid = 1'b0;
    imem_resp_data  = 32'h0;
    #1;
    n = 0;
    while (!out_valid && n < 20) begin
      tick();
      #1;
      n++;
    end
    check("out_valid", {31'b0, out_valid}, 32'd1);
    if (sb.size() > 0) begin
      e = sb.pop_front();
      check("out_pc", out_pc, e.pc);
      check("out_inst", out_inst, e.inst);
      repeat (v.stall) begin
        tick();
        #1;
        check("bp_valid", {31'b0, out_valid}, 32'd1);
        check("bp_pc", out_pc, e.pc);
        check("bp_inst", out_inst, e.inst);
        check("bp_noreq", {31'b0, imem_req_valid}, 32'd0);
        check("bp_count", fetch_count, v.exp_cnt - 32'd1);
      end
    end else begin
      check("sb_empty_pop", 32'd0, 32'd1);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    #1;
    check("fetch_count", fetch_count, v.exp_cnt);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{32'h0000_0013, 0, 0, 32'h8000_0000, 32'd1};
    vecs[1] = '{32'h0000_0013, 0, 0, 32'h8000_0004, 32'd2};
    vecs[2] = '{32'h0000_0013, 0, 0, 32'h8000_0008, 32'd3};
    vecs[3] = '{32'h00a0_0093, 2, 5, 32'h8000_000C, 32'd4};
    vecs[4] = '{32'hDEAD_BEEF, 1, 0, 32'h8000_0010, 32'd5};

    rst             = 1'b0;
    rst2            = 1'b0;
    imem_req_ready  = 1'b0;
    imem_resp_valid = 1'b0;
    imem_resp_data  = 32'h0;
    out_ready       = 1'b0;
    redirect_valid  = 1'b0;
    redirect_pc     = 32'h0;

    @(negedge clk);
    @(negedge clk);
    #1;
    check("rst_req_valid", {31'b0, imem_req_valid}, 32'd0);
    check("rst_out_valid", {31'b0, out_valid}, 32'd0);
    check("rst_halted", {31'b0, halted}, 32'd0);
    check("rst_count", fetch_count, 32'd0);
    check("rst_out_pc", out_pc, 32'd0);
    check("rst_out_inst", out_inst, 32'd0);
    rst = 1'b1;
    #1;
    check("first_req", {31'b0, imem_req_valid}, 32'd1);
    check("first_addr", imem_req_addr, 32'h8000_0000);

    for (int i = 0; i < 5; i++) begin
      fetch_one(vecs[i]);
    end

    // redirect while waiting: stale response dropped
    imem_req_ready = 1'b1;
    #1;
    check("rw_addr", imem_req_addr, 32'h8000_0014);
    tick();
    imem_req_ready = 1'b0;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h8000_0103;
    tick();
    redirect_valid = 1'b0;
    #1;
    check("rw_kill_noreq", {31'b0, imem_req_valid}, 32'd0);
    check("rw_kill_noout", {31'b0, out_valid}, 32'd0);
    imem_resp_valid = 1'b1;
    imem_resp_data  = 32'h0BAD_0BAD;
    tick();
    imem_resp_valid = 1'b0;
    #1;
    check("rw_stale_out", {31'b0, out_valid}, 32'd0);
    check("rw_new_req", {31'b0, imem_req_valid}, 32'd1);
    check("rw_new_addr", imem_req_addr, 32'h8000_0100);
    check("rw_count", fetch_count, 32'd5);

    // redirect in OUT outranks a ready decode
    imem_req_ready = 1'b1;
    tick();
    imem_req_ready  = 1'b0;
    imem_resp_valid = 1'b1;
    imem_resp_data  = 32'h0000_0013;
    tick();
    imem_resp_valid = 1'b0;
    #1;
    check("ro_valid", {31'b0, out_valid}, 32'd1);
    check("ro_pc", out_pc, 32'h8000_0100);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h8000_0202;
    out_ready      = 1'b1;
    #1;
    check("ro_masked", {31'b0, out_valid}, 32'd0);
    tick();
    redirect_valid = 1'b0;
    out_ready      = 1'b0;
    #1;
    check("ro_count", fetch_count, 32'd5);
    check("ro_addr", imem_req_addr, 32'h8000_0200);

    // ebreak halts, redirect ignored, reset recovers
    fetch_one('{EBREAK, 0, 0, 32'h8000_0200, 32'd6});
    check("hlt_halted", {31'b0, halted}, 32'd1);
    check("hlt_noreq", {31'b0, imem_req_valid}, 32'd0);
    check("hlt_noout", {31'b0, out_valid}, 32'd0);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h8000_0300;
    imem_req_ready = 1'b1;
    tick();
    redirect_valid = 1'b0;
    tick();
    #1;
    check("hlt_sticky", {31'b0, halted}, 32'd1);
    check("hlt_sticky_req", {31'b0, imem_req_valid}, 32'd0);
    imem_req_ready = 1'b0;
    rst = 1'b0;
    #1;
    check("hlt_rst_halted", {31'b0, halted}, 32'd0);
    check("hlt_rst_count", fetch_count, 32'd0);
    tick();
    rst = 1'b1;
    #1;
    check("hlt_rel_req", {31'b0, imem_req_valid}, 32'd1);
    check("hlt_rel_addr", imem_req_addr, 32'h8000_0000);

    // async reset in OUT, then a late response
    imem_req_ready = 1'b1;
    tick();
    imem_req_ready  = 1'b0;
    imem_resp_valid = 1'b1;
    imem_resp_data  = 32'h1234_5678;
    tick();
    imem_resp_valid = 1'b0;
    #1;
    check("ar_valid", {31'b0, out_valid}, 32'd1);
    check("ar_inst", out_inst, 32'h1234_5678);
    #1;
    rst = 1'b0;
    #1;
    check("ar_out_valid", {31'b0, out_valid}, 32'd0);
    check("ar_out_inst", out_inst, 32'd0);
    check("ar_out_pc", out_pc, 32'd0);
    check("ar_req_valid", {31'b0, imem_req_valid}, 32'd0);
    check("ar_count", fetch_count, 32'd0);
    tick();
    rst = 1'b1;
    imem_resp_valid = 1'b1;
    imem_resp_data  = 32'h1234_5678;
    tick();
    imem_resp_valid = 1'b0;
    #1;
    check("late_noout", {31'b0, out_valid}, 32'd0);
    check("late_req", {31'b0, imem_req_valid}, 32'd1);
    check("late_addr", imem_req_addr, 32'h8000_0000);

    // pc wrap on the second instance
    rst = 1'b0;
    tick();
    rst2 = 1'b1;
    imem_req_ready = 1'b1;
    #1;
    check("wr_req", {31'b0, w_req_valid}, 32'd1);
    check("wr_addr0", w_req_addr, 32'hFFFF_FFFC);
    tick();
    imem_req_ready  = 1'b0;
    imem_resp_valid = 1'b1;
    imem_resp_data  = 32'h0000_0013;
    tick();
    imem_resp_valid = 1'b0;
    out_ready       = 1'b1;
    #1;
    check("wr_out_pc", w_out_pc, 32'hFFFF_FFFC);
    tick();
    out_ready = 1'b0;
    #1;
    check("wr_addr1", w_req_addr, 32'h0000_0000);
    check("wr_count", w_count, 32'd1);

    check("sb_drained", sb.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
